vdcorput_seq: RTL and testbench

- Iterative integer van der Corput sequence engine: one radical-inverse value per pop request, computed one base-BASE digit per clock.
- Sits directly upstream of the Halton generator, which instantiates two copies (BASE=2 and BASE=3) and combines their results into its `halton_out_0`/`halton_out_1` pair.
- Produces the lds-gen integer form: `vdc(k) = Σ digit_i(k) · BASE^(SCALE-1-i)`, range [0, BASE^SCALE).

---
 rtl/lds_pkg.sv | 23 ++
 rtl/vdcorput_seq.sv | 109 ++++++++++
 tb/tb_vdcorput_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lds_pkg.sv
// Shared definitions for the low-discrepancy sequence blocks: state encoding,
// default datapath width and a constant integer power helper.
package lds_pkg;

    localparam int LDS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } vdc_state_t;

    // Evaluated at elaboration only; 64 bits holds BASE^SCALE for any WIDTH <= 63.
    function automatic logic [63:0] ipow(input int base, input int exp);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < exp; i++) begin
            r = r * 64'(base);
        end
        return r;
    endfunction

endpackage

// File: rtl/vdcorput_seq.sv
// Iterative integer van der Corput engine: one radical-inverse value per pop,
// one base-BASE digit resolved per clock, most significant weight first.
module vdcorput_seq
    import lds_pkg::*;
#(
    parameter int BASE  = 2,
    parameter int SCALE = 10,
    parameter int WIDTH = LDS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pop_enable,
    input  logic             reseed_enable,
    input  logic [WIDTH-1:0] seed,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] vdc_out
);

    localparam int               IDXW     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [WIDTH-1:0] BASE_W   = WIDTH'(BASE);
    localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(SCALE - 1);

    if (BASE < 2 || BASE > 16) begin : g_bad_base
        $error("vdcorput_seq: BASE must lie in 2..16");
    end
    if (WIDTH < 64 && ipow(BASE, SCALE) > (64'd1 << WIDTH)) begin : g_bad_scale
        $error("vdcorput_seq: BASE**SCALE does not fit in WIDTH bits");
    end

    // Digit weights BASE^(SCALE-1-i), fixed at elaboration.
    logic [WIDTH-1:0] pow [SCALE];
    for (genvar i = 0; i < SCALE; i++) begin : g_pow
        assign pow[i] = WIDTH'(ipow(BASE, SCALE - 1 - i));
    end

    vdc_state_t       state;
    vdc_state_t       state_nxt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] digit;
    logic [WIDTH-1:0] acc;
    logic [IDXW-1:0]  idx;
    logic             start;

    // A pop is taken only from a fully quiet engine: IDLE with no valid pulse showing.
    assign busy  = (state != IDLE) || valid;
    assign start = (state == IDLE) && !valid && pop_enable && !reseed_enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem / BASE_W;
        digit     = rem % BASE_W;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (rem_nxt == '0 || idx == IDX_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (reseed_enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            rem     <= '0;
            acc     <= '0;
            idx     <= '0;
            vdc_out <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (reseed_enable) begin
                count <= seed;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            count <= count + 1'b1;
                            rem   <= count + 1'b1;
                            acc   <= '0;
                            idx   <= '0;
                        end
                    end
                    CALC: begin
                        acc <= acc + digit * pow[idx];
                        rem <= rem_nxt;
                        idx <= idx + 1'b1;
                    end
                    DONE: begin
                        vdc_out <= acc;
                        valid   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vdcorput_seq.sv
// Bench for vdcorput_seq: a BASE=2/SCALE=10 and a BASE=3/SCALE=7 instance,
// expected values and latencies queued at pop time and matched on valid.
module tb_vdcorput_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;

    logic        pop2 = 1'b0, reseed2 = 1'b0;
    logic [31:0] seed2 = '0;
    logic        busy2, valid2;
    logic [31:0] vdc2;

    logic        pop3 = 1'b0, reseed3 = 1'b0;
    logic [31:0] seed3 = '0;
    logic        busy3, valid3;
    logic [31:0] vdc3;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q2 [$];
    logic [31:0] exp_q3 [$];
    int          lat_q2 [$];
    int          lat_q3 [$];
    int unsigned acc_q2 [$];
    int unsigned acc_q3 [$];

    logic [31:0] exp_vals2 [4] = '{32'd512, 32'd256, 32'd768, 32'd128};
    int          exp_lat2  [4] = '{2, 3, 3, 4};
    logic [31:0] exp_vals3 [4] = '{32'd729, 32'd1458, 32'd243, 32'd972};
    int          exp_lat3  [4] = '{2, 2, 3, 3};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vdcorput_seq #(.BASE(2), .SCALE(10), .WIDTH(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .pop_enable(pop2), .reseed_enable(reseed2),
        .seed(seed2), .busy(busy2), .valid(valid2), .vdc_out(vdc2)
    );

    vdcorput_seq #(.BASE(3), .SCALE(7), .WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .pop_enable(pop3), .reseed_enable(reseed3),
        .seed(seed3), .busy(busy3), .valid(valid3), .vdc_out(vdc3)
    );

    // ---------------- checking / model ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] vdc_model(input logic [63:0] k, input int base, input int scale);
        logic [63:0] acc, w, kk;
        acc = '0;
        kk  = k;
        for (int i = 0; i < scale; i++) begin
            w = 64'd1;
            for (int j = 0; j < scale - 1 - i; j++) w = w * 64'(base);
            acc = acc + (kk % 64'(base)) * w;
            kk  = kk / 64'(base);
        end
        return acc[31:0];
    endfunction

    function automatic int exp_latency(input logic [63:0] k, input int base, input int scale);
        logic [63:0] kk;
        int n;
        kk = k;
        n  = 0;
        while (kk != 0) begin
            n++;
            kk = kk / 64'(base);
        end
        if (n < 1) n = 1;
        if (n > scale) n = scale;
        return n + 1;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [31:0] m_exp;
    int          m_lat;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid2) begin
                if (exp_q2.size() == 0) begin
                    check("extra_valid2", valid2, 1'b0);
                end else begin
                    m_exp = exp_q2.pop_front();
                    m_lat = lat_q2.pop_front();
                    check("vdc2", vdc2, m_exp);
                    if (acc_q2.size() == 0) check("pop_seen2", acc_q2.size(), 1);
                    else check("lat2", cyc - acc_q2.pop_front(), m_lat);
                end
            end
            if (pop2 && !busy2 && !reseed2) acc_q2.push_back(cyc + 1);

            if (valid3) begin
                if (exp_q3.size() == 0) begin
                    check("extra_valid3", valid3, 1'b0);
                end else begin
                    m_exp = exp_q3.pop_front();
                    m_lat = lat_q3.pop_front();
                    check("vdc3", vdc3, m_exp);
                    if (acc_q3.size() == 0) check("pop_seen3", acc_q3.size(), 1);
                    else check("lat3", cyc - acc_q3.pop_front(), m_lat);
                end
            end
            if (pop3 && !busy3 && !reseed3) acc_q3.push_back(cyc + 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push2(input logic [63:0] k);
        exp_q2.push_back(vdc_model(k, 2, 10));
        lat_q2.push_back(exp_latency(k, 2, 10));
    endtask

    task automatic push3(input logic [63:0] k);
        exp_q3.push_back(vdc_model(k, 3, 7));
        lat_q3.push_back(exp_latency(k, 3, 7));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy2 || busy3); i++) tick();
        if (busy2 || busy3) check("idle_timeout", {busy2, busy3}, 2'b00);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q2.size() != 0 || exp_q3.size() != 0); i++) tick();
        if (exp_q2.size() != 0 || exp_q3.size() != 0) begin
            check("drain_timeout", exp_q2.size() + exp_q3.size(), 0);
            exp_q2.delete(); lat_q2.delete(); acc_q2.delete();
            exp_q3.delete(); lat_q3.delete(); acc_q3.delete();
        end
    endtask

    task automatic pop2_once();
        wait_idle();
        pop2 = 1'b1;
        tick();
        pop2 = 1'b0;
    endtask

    task automatic reseed2_to(input logic [31:0] s);
        wait_idle();
        seed2   = s;
        reseed2 = 1'b1;
        tick();
        reseed2 = 1'b0;
    endtask

    task automatic reseed3_to(input logic [31:0] s);
        wait_idle();
        seed3   = s;
        reseed3 = 1'b1;
        tick();
        reseed3 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] s;

        repeat (3) tick();
        check("rst_busy2", busy2, 1'b0);
        check("rst_valid2", valid2, 1'b0);
        check("rst_vdc2", vdc2, 32'd0);
        check("rst_busy3", busy3, 1'b0);
        check("rst_valid3", valid3, 1'b0);
        check("rst_vdc3", vdc3, 32'd0);
        rst_n = 1'b1;
        tick();

        // First four indices on both radices.
        for (int k = 0; k < 4; k++) begin
            wait_idle();
            exp_q2.push_back(exp_vals2[k]); lat_q2.push_back(exp_lat2[k]);
            exp_q3.push_back(exp_vals3[k]); lat_q3.push_back(exp_lat3[k]);
            pop2 = 1'b1; pop3 = 1'b1;
            tick();
            pop2 = 1'b0; pop3 = 1'b0;
        end
        drain();

        // Reseed then pop: index seed+1.
        reseed2_to(32'd7);
        exp_q2.push_back(32'd64); lat_q2.push_back(5);
        pop2_once();
        drain();

        // Simultaneous reseed and pop: only the reseed lands.
        seed2 = 32'd7; reseed2 = 1'b1; pop2 = 1'b1;
        tick();
        reseed2 = 1'b0; pop2 = 1'b0;
        repeat (10) tick();
        exp_q2.push_back(32'd64); lat_q2.push_back(5);
        pop2_once();
        drain();

        // Reseed aborting a computation: no valid, output held.
        reseed2_to(32'd2);
        pop2_once();
        tick();
        seed2 = 32'd7; reseed2 = 1'b1;
        tick();
        reseed2 = 1'b0;
        acc_q2.delete();
        repeat (12) tick();
        check("hold_after_abort", vdc2, 32'd64);
        check("idle_after_abort", busy2, 1'b0);
        exp_q2.push_back(32'd64); lat_q2.push_back(5);
        pop2_once();
        drain();

        // Pop held high: one value per completed computation.
        reseed2_to(32'd0);
        for (int k = 1; k <= 6; k++) push2(k);
        pop2 = 1'b1;
        drain();
        pop2 = 1'b0;
        repeat (15) tick();

        // Counter wrap to 0, then continue at 1.
        reseed2_to(32'hFFFF_FFFF);
        exp_q2.push_back(32'd0); lat_q2.push_back(2);
        pop2_once();
        drain();
        exp_q2.push_back(32'd512); lat_q2.push_back(2);
        pop2_once();
        drain();

        // Digits beyond SCALE are dropped.
        reseed2_to(32'd1023);
        exp_q2.push_back(32'd0); lat_q2.push_back(11);
        pop2_once();
        drain();

        // Random indices on both radices.
        for (int i = 0; i < 4; i++) begin
            s = $urandom_range(0, 100000);
            reseed2_to(s);
            push2(64'(s) + 64'd1);
            pop2_once();
            s = $urandom_range(0, 3000);
            reseed3_to(s);
            push3(64'(s) + 64'd1);
            wait_idle();
            pop3 = 1'b1;
            tick();
            pop3 = 1'b0;
            drain();
        end

        // Reset in the middle of a computation of k=7.
        reseed2_to(32'd6);
        pop2_once();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy2, 1'b0);
        check("midrst_valid", valid2, 1'b0);
        check("midrst_vdc", vdc2, 32'd0);
        exp_q2.delete(); lat_q2.delete(); acc_q2.delete();
        exp_q3.delete(); lat_q3.delete(); acc_q3.delete();
        tick();
        rst_n = 1'b1;
        tick();
        exp_q2.push_back(32'd512); lat_q2.push_back(2);
        pop2_once();
        drain();
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
